spi_adc_model: RTL and testbench

Synthesizable, parametrised SPI slave that emulates a multi-channel serial ADC, such as a PMOD ADC, for driving the SPI master under test on FPGA and in simulation. It oversamples the SPI pins on the system clock and returns one DATA_W-bit sample per frame, MSB first, padded with trailing zeros to FRAME_W bits. Each channel holds a ramp that advances by STEP after every completed frame. The channel for each frame is either selected over SDI or cycled round-robin.

---
 rtl/spi_adc_pkg.sv | 24 ++
 rtl/spi_sync_edge.sv | 35 +++
 rtl/spi_adc_model.sv | 187 ++++++++++++++++++
 tb/tb_spi_adc_model.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_adc_pkg.sv
// Shared types and helpers for the SPI ADC model: FSM state encoding,
// channel index width and a constant-foldable ceil(log2) helper.
package spi_adc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    localparam int CHAN_W = 3;

    // ceil(log2(v)); returns 0 for v <= 1
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_adc_model.sv
// SPI slave emulating a multi-channel serial ADC (CPHA=0). Each channel
// holds a ramp that advances by STEP per completed frame; a frame returns
// the selected ramp MSB first, zero padded to FRAME_W bits.
// Optional build macro SPI_ADC_CHSEL_EN: the first clog2(N_CHAN) sdi bits
// of a frame select the channel for the following frame; otherwise the
// channel advances round-robin and sdi is ignored.
module spi_adc_model
    import spi_adc_pkg::*;
#(
    parameter int   DATA_W  = 12,
    parameter int   FRAME_W = 16,
    parameter int   N_CHAN  = 1,
    parameter int   STEP    = 3,
    parameter logic CPOL    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_csb,
    input  logic              spi_sck,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    output logic              spi_sdo_oe,
    input  logic              ld_valid,
    input  logic [CHAN_W-1:0] ld_chan,
    input  logic [DATA_W-1:0] ld_data,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic [CHAN_W-1:0] chan_cur
);

    localparam int PAD   = FRAME_W - DATA_W;
    localparam int CNT_W = clog2(FRAME_W + 1);
    localparam int SEL_W = clog2(N_CHAN);

    logic csb_rise, csb_fall, csb_level_unused;
    logic sck_rise, sck_fall, sck_level_unused;
    logic sdi_s, sdi_rise_unused, sdi_fall_unused;
    logic lead, trail;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_csb (
        .clk(clk), .reset(reset), .d_i(spi_csb),
        .level_o(csb_level_unused), .rise_o(csb_rise), .fall_o(csb_fall)
    );
    spi_sync_edge #(.RST_VAL(CPOL)) u_sync_sck (
        .clk(clk), .reset(reset), .d_i(spi_sck),
        .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .reset(reset), .d_i(spi_sdi),
        .level_o(sdi_s), .rise_o(sdi_rise_unused), .fall_o(sdi_fall_unused)
    );

    // leading edge leaves the idle level, trailing edge returns to it
    assign lead  = CPOL ? sck_fall : sck_rise;
    assign trail = CPOL ? sck_rise : sck_fall;

    state_e              state_q, state_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [FRAME_W-1:0]  sdi_shift_q, sdi_shift_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic                sdo_q, sdo_d;
    logic                oe_q, oe_d;
    logic [15:0]         count_q, count_d;
    logic [CHAN_W-1:0]   chan_q, chan_d;
    logic [DATA_W-1:0]   ramp_q [N_CHAN];
    logic [DATA_W-1:0]   ramp_d [N_CHAN];
    logic [DATA_W-1:0]   snapshot;
    logic [CHAN_W-1:0]   next_chan;

`ifdef SPI_ADC_CHSEL_EN
    localparam int SEL_SH = FRAME_W - SEL_W;
    logic [CHAN_W-1:0] sel_chan;
    // first SEL_W sdi bits of the frame sit at the top of sdi_shift
    assign sel_chan  = CHAN_W'(sdi_shift_q >> SEL_SH);
    assign next_chan = (int'(sel_chan) < N_CHAN) ? sel_chan : '0;
`else
    logic sdi_shift_unused;
    assign sdi_shift_unused = ^sdi_shift_q;
    assign next_chan = (int'(chan_q) == N_CHAN - 1) ? '0 : chan_q + CHAN_W'(1);
`endif

    // ramp value of the channel the next frame will return
    always_comb begin
        snapshot = '0;
        for (int c = 0; c < N_CHAN; c++) begin
            if (chan_q == CHAN_W'(c)) snapshot = ramp_q[c];
        end
    end

    // frame FSM, shifter, ramp update and load arbitration
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        sdi_shift_d = sdi_shift_q;
        bitcnt_d    = bitcnt_q;
        sdo_d       = sdo_q;
        oe_d        = oe_q;
        count_d     = count_q;
        chan_d      = chan_q;
        ramp_d      = ramp_q;

        // after csb fall every trailing edge moves the next bit onto sdo
        if (state_q != IDLE && trail) begin
            shift_d = shift_q << 1;
            sdo_d   = shift_q[FRAME_W-2];
        end

        case (state_q)
            IDLE: begin
                if (csb_fall) begin
                    state_d     = ACTIVE;
                    shift_d     = FRAME_W'(snapshot) << PAD;
                    sdi_shift_d = '0;
                    bitcnt_d    = '0;
                    oe_d        = 1'b1;
                    sdo_d       = snapshot[DATA_W-1];
                end
            end
            ACTIVE: begin
                if (bitcnt_q == CNT_W'(FRAME_W)) begin
                    state_d = DONE;
                end else if (lead) begin
                    bitcnt_d    = bitcnt_q + CNT_W'(1);
                    sdi_shift_d = {sdi_shift_q[FRAME_W-2:0], sdi_s};
                end
            end
            DONE: begin
                for (int c = 0; c < N_CHAN; c++) begin
                    if (chan_q == CHAN_W'(c)) ramp_d[c] = ramp_q[c] + DATA_W'(STEP);
                end
                count_d = count_q + 16'd1;
                chan_d  = next_chan;
                state_d = DRAIN;
            end
            default: ;
        endcase

        // a load overrides the DONE increment on the same channel
        if (ld_valid) begin
            for (int c = 0; c < N_CHAN; c++) begin
                if (ld_chan == CHAN_W'(c)) ramp_d[c] = ld_data;
            end
        end

        // csb rise ends the frame; a coincident sck edge is dropped
        if (csb_rise) begin
            state_d     = IDLE;
            oe_d        = 1'b0;
            sdo_d       = 1'b0;
            shift_d     = shift_q;
            sdi_shift_d = sdi_shift_q;
            bitcnt_d    = bitcnt_q;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            sdi_shift_q <= '0;
            bitcnt_q    <= '0;
            sdo_q       <= 1'b0;
            oe_q        <= 1'b0;
            count_q     <= '0;
            chan_q      <= '0;
            for (int c = 0; c < N_CHAN; c++) ramp_q[c] <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            sdi_shift_q <= sdi_shift_d;
            bitcnt_q    <= bitcnt_d;
            sdo_q       <= sdo_d;
            oe_q        <= oe_d;
            count_q     <= count_d;
            chan_q      <= chan_d;
            ramp_q      <= ramp_d;
        end
    end

    assign spi_sdo     = sdo_q;
    assign spi_sdo_oe  = oe_q;
    assign frame_done  = (state_q == DONE);
    assign frame_count = count_q;
    assign chan_cur    = chan_q;

endmodule

// File: tb/tb_spi_adc_model.sv
// Bench for spi_adc_model: a single-channel and a four-channel instance
// share the SPI pins and load port; a behavioural model predicts each
// returned word, frame counts, channel sequence and done pulses.
module tb_spi_adc_model;

    logic        clk = 1'b0;
    logic        reset, csb, sck, sdi, ld_valid;
    logic [2:0]  ld_chan;
    logic [11:0] ld_data;

    logic [1:0]       sdo_v, oe_v, done_v;
    logic [1:0][15:0] cnt_v;
    logic [1:0][2:0]  chan_v;

    int nchk = 0;
    int nfail = 0;
    int pulses [2] = '{0, 0};

    // reference model state: [0] = 1-channel DUT, [1] = 4-channel DUT
    logic [11:0] m_ramp [2][8];
    int          m_chan [2];
    int          m_cnt  [2];
    int          m_pulses [2] = '{0, 0};
    int          NCH [2] = '{1, 4};

    spi_adc_model #(.N_CHAN(1)) u_dut1 (
        .clk(clk), .reset(reset), .spi_csb(csb), .spi_sck(sck), .spi_sdi(sdi),
        .spi_sdo(sdo_v[0]), .spi_sdo_oe(oe_v[0]), .ld_valid(ld_valid),
        .ld_chan(ld_chan), .ld_data(ld_data), .frame_done(done_v[0]),
        .frame_count(cnt_v[0]), .chan_cur(chan_v[0])
    );
    spi_adc_model #(.N_CHAN(4)) u_dut4 (
        .clk(clk), .reset(reset), .spi_csb(csb), .spi_sck(sck), .spi_sdi(sdi),
        .spi_sdo(sdo_v[1]), .spi_sdo_oe(oe_v[1]), .ld_valid(ld_valid),
        .ld_chan(ld_chan), .ld_data(ld_data), .frame_done(done_v[1]),
        .frame_count(cnt_v[1]), .chan_cur(chan_v[1])
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_v[0]) pulses[0]++;
        if (done_v[1]) pulses[1]++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 8; c++) m_ramp[d][c] = '0;
            m_chan[d] = 0;
            m_cnt[d]  = 0;
        end
    endfunction

    function automatic void m_load(input int ch, input logic [11:0] v);
        for (int d = 0; d < 2; d++)
            if (ch < NCH[d]) m_ramp[d][ch] = v;
    endfunction

    function automatic void m_done(input logic [15:0] sdi_w);
        for (int d = 0; d < 2; d++) begin
            m_ramp[d][m_chan[d]] = m_ramp[d][m_chan[d]] + 12'd3;
            m_cnt[d] = (m_cnt[d] + 1) % 65536;
            m_pulses[d]++;
`ifdef SPI_ADC_CHSEL_EN
            m_chan[d] = (NCH[d] > 1) ? int'(sdi_w[15:14]) : 0;
`else
            m_chan[d] = (m_chan[d] + 1) % NCH[d];
`endif
        end
    endfunction

    task automatic do_load(input int ch, input logic [11:0] v);
        @(negedge clk);
        ld_valid = 1'b1; ld_chan = 3'(ch); ld_data = v;
        @(negedge clk);
        ld_valid = 1'b0;
        m_load(ch, v);
    endtask

    task automatic check_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_count"}, 32'(cnt_v[d]), 32'(m_cnt[d]));
            check({tag, "_chan"}, 32'(chan_v[d]), 32'(m_chan[d]));
            check({tag, "_pulses"}, 32'(pulses[d]), 32'(m_pulses[d]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_oe", 32'(oe_v), 32'h0);
        check("rst_sdo", 32'(sdo_v), 32'h0);
        check("rst_done", 32'(done_v), 32'h0);
        check("rst_cnt", 32'(cnt_v), 32'h0);
        check("rst_chan", 32'(chan_v), 32'h0);
        csb = 1'b1; sck = 1'b0; sdi = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m_reset();
        repeat (4) @(negedge clk);
    endtask

    // ld_when: 0 none, 1 mid-frame (after bit 4), 2 during the DONE cycle
    task automatic frame(input int nbits, input logic [15:0] sdi_w, input int ld_when,
                         input int ld_ch, input logic [11:0] ld_d, input bit hold);
        logic [15:0] exp_w [2];
        logic [15:0] got_w [2];
        for (int d = 0; d < 2; d++) begin
            exp_w[d] = {m_ramp[d][m_chan[d]], 4'h0};
            got_w[d] = '0;
        end
        @(negedge clk) csb = 1'b0;
        @(negedge clk);
        @(negedge clk) check("oe_pre_lat", 32'(oe_v), 32'h0);
        @(negedge clk) check("oe_lat3", 32'(oe_v), 32'h3);
        @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            for (int d = 0; d < 2; d++) got_w[d][15-i] = sdo_v[d];
            sdi = sdi_w[15-i];
            sck = 1'b1;
            for (int n = 1; n <= 4; n++) begin
                @(negedge clk);
                if (i == 15 && n == 3) check("done_early", 32'(done_v), 32'h0);
                if (i == 15 && n == 4) check("done_lat4", 32'(done_v), 32'h3);
            end
            sck = 1'b0;
            if ((ld_when == 1 && i == 4) || (ld_when == 2 && i == 15)) begin
                ld_valid = 1'b1; ld_chan = 3'(ld_ch); ld_data = ld_d;
                if (ld_when == 1) m_load(ld_ch, ld_d);
            end
            for (int n = 1; n <= 4; n++) begin
                @(negedge clk);
                if (n == 1) ld_valid = 1'b0;
            end
        end
        if (nbits == 16) begin
            m_done(sdi_w);
            if (ld_when == 2) m_load(ld_ch, ld_d);
        end
        if (hold) return;
        @(negedge clk) csb = 1'b1;
        @(negedge clk);
        @(negedge clk) check("oe_hold", 32'(oe_v), 32'h3);
        @(negedge clk);
        check("oe_rise_lat3", 32'(oe_v), 32'h0);
        check("sdo_idle", 32'(sdo_v), 32'h0);
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (nbits == 16) check(d == 0 ? "word_c1" : "word_c4", 32'(got_w[d]), 32'(exp_w[d]));
            else check(d == 0 ? "partial_c1" : "partial_c4",
                       32'(got_w[d] >> (16 - nbits)), 32'(exp_w[d] >> (16 - nbits)));
        end
        check_state("frame");
    endtask

    initial begin
        reset = 1'b1; csb = 1'b1; sck = 1'b0; sdi = 1'b0;
        ld_valid = 1'b0; ld_chan = '0; ld_data = '0;
        m_reset();
        repeat (4) @(negedge clk);
        check("init_oe", 32'(oe_v), 32'h0);
        check("init_cnt", 32'(cnt_v), 32'h0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        // three default frames: 0x0000, 0x0030, 0x0060 on the single channel
        repeat (3) frame(16, 16'h0000, 0, 0, 12'h0, 1'b0);
        check("three_frames_count", 32'(cnt_v[0]), 32'd3);

        // 12-bit wrap of the ramp
        do_load(0, 12'hFFE);
        frame(16, 16'h0000, 0, 0, 12'h0, 1'b0);
        frame(16, 16'h0000, 0, 0, 12'h0, 1'b0);

        // aborted frame after 9 periods, then the same sample in full
        frame(9, 16'h0000, 0, 0, 12'h0, 1'b0);
        frame(16, 16'h0000, 0, 0, 12'h0, 1'b0);

        // channel select pattern 1,0 at the start of the frame
        frame(16, 16'h8000, 0, 0, 12'h0, 1'b0);

        // load during a frame, and a load colliding with the DONE update
        frame(16, 16'(($urandom & 32'h3FFF) | 32'h4000), 1, m_chan[1], 12'h555, 1'b0);
        frame(16, 16'h4000, 2, m_chan[1], 12'hABC, 1'b0);
        frame(16, 16'h0000, 0, 0, 12'h0, 1'b0);

        // out-of-range loads are ignored
        do_load(5, 12'h777);
        frame(16, 16'h0000, 0, 0, 12'h0, 1'b0);

        // reset in the middle of a frame
        frame(7, 16'h0000, 0, 0, 12'h0, 1'b1);
        do_reset();
        frame(16, 16'h0000, 0, 0, 12'h0, 1'b0);

        // four loaded channels returned in order
        do_reset();
        for (int c = 0; c < 4; c++) do_load(c, 12'(32'h100 * (c + 1)));
        for (int k = 0; k < 4; k++) frame(16, {2'((k + 1) % 4), 14'h0}, 0, 0, 12'h0, 1'b0);

        // randomized traffic
        for (int r = 0; r < 24; r++) begin
            int sel, nb, lw;
            sel = int'($urandom_range(0, 9));
            if (sel < 3) do_load(int'($urandom_range(0, 7)), 12'($urandom));
            nb = (sel == 9) ? int'($urandom_range(1, 15)) : 16;
            lw = (nb == 16) ? int'($urandom_range(0, 2)) : 0;
            frame(nb, 16'($urandom), lw, int'($urandom_range(0, 4)), 12'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
